// File: rtl/onehot_seq_ctrl.sv
// Sequencer for an N-iteration shift/add multiplier, with one-hot state encoding.
// Any illegal state code recovers to IDLE and raises state_err for that one cycle.
module onehot_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mbit,
    output logic [4:0]    state,
    output logic          ld,
    output logic          clr_acc,
    output logic          add_en,
    output logic          shift_en,
    output logic [CW-1:0] cnt,
    output logic          busy,
    output logic          done,
    output logic          state_err
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | load operands, clear accumulator, iteration count reset
    // CHECK | add partial product when multiplier LSB is set
    // SHIFT | shift accumulator/multiplier, count the iteration
    // DONE  | one-cycle completion, then back to IDLE
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_CHECK = 5'b00100,
        S_SHIFT = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    // Plain vectors rather than the enum type, so that corrupted codes stay representable.
    logic [4:0]    state_q;
    logic [4:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld        = 1'b0;
        clr_acc   = 1'b0;
        add_en    = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        state_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                ld      = 1'b1;
                clr_acc = 1'b1;
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_CHECK;
            end
            S_CHECK: begin
                add_en  = mbit;
                busy    = 1'b1;
                state_d = abort ? S_IDLE : S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CNT_LAST) ? S_DONE : S_CHECK;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                // Zero or multiple bits set: every control output stays low this cycle.
                state_err = 1'b1;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign state = state_q;
    assign cnt   = cnt_q;

endmodule

// File: tb/tb_onehot_seq_ctrl.sv
// Scoreboard bench for onehot_seq_ctrl: stimulus queues the expected per-cycle outputs,
// and a negedge monitor compares them against the DUT.
module tb_onehot_seq_ctrl;
    localparam int N  = 8;
    localparam int CW = 4;

    localparam logic [4:0] IDLE  = 5'b00001;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] CHECK = 5'b00100;
    localparam logic [4:0] SHIFT = 5'b01000;
    localparam logic [4:0] DONE  = 5'b10000;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mbit  = 1'b0;
    logic [4:0]    state;
    logic          ld, clr_acc, add_en, shift_en, busy, done, state_err;
    logic [CW-1:0] cnt;

    typedef struct packed {
        logic [4:0] st;
        logic [3:0] cnt;
        logic       ld;
        logic       clr;
        logic       add;
        logic       shf;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t  sb[$];
    string nm[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    onehot_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .mbit      (mbit),
        .state     (state),
        .ld        (ld),
        .clr_acc   (clr_acc),
        .add_en    (add_en),
        .shift_en  (shift_en),
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .state_err (state_err)
    );

    function automatic exp_t mk(input logic [4:0] st, input logic [3:0] c, input logic a);
        exp_t e;
        logic legal;
        legal  = $onehot(st);
        e.st   = st;
        e.cnt  = c;
        e.ld   = (st == LOAD);
        e.clr  = (st == LOAD);
        e.add  = (st == CHECK) && a;
        e.shf  = (st == SHIFT);
        e.busy = legal && (st != IDLE);
        e.done = (st == DONE);
        e.err  = !legal;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t  e;
        exp_t  act;
        string n;
        if (sb.size() > 0) begin
            e        = sb.pop_front();
            n        = nm.pop_front();
            act.st   = state;
            act.cnt  = cnt;
            act.ld   = ld;
            act.clr  = clr_acc;
            act.add  = add_en;
            act.shf  = shift_en;
            act.busy = busy;
            act.done = done;
            act.err  = state_err;
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got state=%b cnt=%0d ld/clr/add/shf/busy/done/err=%b, want state=%b cnt=%0d ld/clr/add/shf/busy/done/err=%b",
                         n, act.st, act.cnt, act[6:0], e.st, e.cnt, e[6:0]);
            end
        end
    end

    // One clock cycle: e is what the DUT must show now; r/s/a/m steer the next edge.
    task automatic step(input logic r, input logic s, input logic a, input logic m,
                        input exp_t e, input string n);
        @(posedge clk);
        #1;
        rst   = r;
        start = s;
        abort = a;
        mbit  = m;
        sb.push_back(e);
        nm.push_back(n);
    endtask

    // Relative cycle r: 0 IDLE(start), 1 LOAD, 2+2i CHECK i, 3+2i SHIFT i, 2N+2 DONE.
    task automatic run_op(input logic [7:0] mpat, input int abort_rel, input int rst_rel,
                          input logic hold, input logic [3:0] cnt0, input string tag);
        int last;
        last = 2 * N + 2;
        for (int r = 0; r <= last; r++) begin
            exp_t e;
            logic m;
            int   i;
            m = 1'b1;
            i = 0;
            if (r == 0)
                e = mk(IDLE, cnt0, 1'b0);
            else if (r == 1)
                e = mk(LOAD, 4'd0, 1'b0);
            else if (r == last)
                e = mk(DONE, 4'(N), 1'b0);
            else begin
                i = (r - 2) / 2;
                if (((r - 2) % 2) == 0) begin
                    m = mpat[i];
                    e = mk(CHECK, 4'(i), m);
                end else begin
                    e = mk(SHIFT, 4'(i), 1'b0);
                end
            end
            step(!(r == rst_rel), (r == 0) || hold, (r == abort_rel), m, e,
                 $sformatf("%s_r%0d", tag, r));
            if (r == abort_rel || r == rst_rel) break;
        end
    endtask

    initial begin
        // Reset overrides start/abort.
        step(1'b0, 1'b1, 1'b1, 1'b0, mk(IDLE, 4'd0, 1'b0), "rst0");
        step(1'b0, 1'b1, 1'b0, 1'b0, mk(IDLE, 4'd0, 1'b0), "rst1");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd0, 1'b0), "rst2");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd0, 1'b0), "idle0");

        run_op(8'hFF, -1, -1, 1'b0, 4'd0, "all1");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd8, 1'b0), "all1_post");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd8, 1'b0), "all1_hold");

        run_op(8'h55, -1, -1, 1'b0, 4'd8, "alt");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd8, 1'b0), "alt_post");

        run_op(8'hFF, 2 + 2 * 3, -1, 1'b0, 4'd8, "abort");
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd3, 1'b0), $sformatf("abort_idle%0d", k));

        run_op(8'hFF, -1, -1, 1'b1, 4'd3, "b2b0");
        run_op(8'hA3, -1, -1, 1'b0, 4'd8, "b2b1");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd8, 1'b0), "b2b_post");

        // Corrupt the state register to a two-hot code.
        @(posedge clk);
        #1;
        dut.state_q = 5'b00110;
        sb.push_back(mk(5'b00110, 4'd8, 1'b0));
        nm.push_back("illegal");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd8, 1'b0), "recover0");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd8, 1'b0), "recover1");

        run_op(8'hFF, -1, 3 + 2 * 5, 1'b0, 4'd8, "rst_mid");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd0, 1'b0), "rst_mid_idle");
        step(1'b1, 1'b1, 1'b1, 1'b0, mk(IDLE, 4'd0, 1'b0), "st_ab");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd0, 1'b0), "st_ab_idle0");
        step(1'b1, 1'b0, 1'b0, 1'b0, mk(IDLE, 4'd0, 1'b0), "st_ab_idle1");

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
